// File: rtl/kalman_sched.sv
// Scalar Kalman step scheduler: owns x/P (signed Q8.8) and sequences
// predict, gain and update through one shared external MUL/DIV unit.
//
// state  | meaning
// IDLE   | waiting for init or a measurement
// PRED   | P += Q (clamped to 0x7FFF)
// DIV    | K = (P << 8) / (P + R), capped at 255
// MUL_X  | dx = (z - x) * K
// UPD_X  | x += dx (saturating)
// MUL_P  | P = P * (1 - K)
// DONE   | est_valid pulse
module kalman_sched #(
  parameter int          W       = 16,
  parameter int          FRAC    = 8,
  parameter logic [15:0] P_RESET = 16'h0100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] cfg_q,
  input  logic [W-1:0] cfg_r,
  input  logic         init,
  input  logic [W-1:0] init_x,
  input  logic [W-1:0] init_p,
  input  logic         meas_valid,
  output logic         meas_ready,
  input  logic [W-1:0] meas_z,
  output logic         est_valid,
  output logic [W-1:0] est_x,
  output logic [W-1:0] est_p,
  output logic         busy,
  output logic         alu_req,
  output logic         alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_ack,
  input  logic [W-1:0] alu_y
);

  localparam logic [W-1:0] P_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE   = W'(1) << FRAC;

  typedef enum logic [2:0] {
    S_IDLE, S_PRED, S_DIV, S_MUL_X, S_UPD_X, S_MUL_P, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   x_q, x_nxt, p_q, p_nxt, z_q, z_nxt, dx_q, dx_nxt;
  logic [FRAC-1:0] k_q, k_nxt, k_sat;
  logic [W-1:0]   q_u, r_u, p_pred, div_b, innov, x_sum, k_ext;

  // Signed W+1-bit value saturated to W bits.
  function automatic logic [W-1:0] sat_s(input logic [W:0] s);
    if (s[W] != s[W-1]) return s[W] ? S_MIN : P_MAX;
    return s[W-1:0];
  endfunction

  // Unsigned W+1-bit sum of two non-negative values clamped to P_MAX.
  function automatic logic [W-1:0] sat_u(input logic [W:0] u);
    if (u[W] || u[W-1]) return P_MAX;
    return u[W-1:0];
  endfunction

  assign q_u    = cfg_q & P_MAX;
  assign r_u    = cfg_r & P_MAX;
  assign p_pred = sat_u({1'b0, p_q} + {1'b0, q_u});
  assign div_b  = sat_u({1'b0, p_q} + {1'b0, r_u});
  assign innov  = sat_s({z_q[W-1], z_q} - {x_q[W-1], x_q});
  assign x_sum  = sat_s({x_q[W-1], x_q} + {dx_q[W-1], dx_q});
  assign k_ext  = {{(W-FRAC){1'b0}}, k_q};
  assign k_sat  = (|alu_y[W-1:FRAC]) ? '1 : alu_y[FRAC-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x_q   <= '0;
      p_q   <= P_RESET;
      z_q   <= '0;
      dx_q  <= '0;
      k_q   <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      p_q   <= p_nxt;
      z_q   <= z_nxt;
      dx_q  <= dx_nxt;
      k_q   <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    p_nxt     = p_q;
    z_nxt     = z_q;
    dx_nxt    = dx_q;
    k_nxt     = k_q;
    alu_req   = 1'b0;
    alu_op    = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_IDLE: begin
        if (init) begin
          x_nxt = init_x;
          p_nxt = init_p & P_MAX;
        end else if (meas_valid) begin
          z_nxt     = meas_z;
          state_nxt = S_PRED;
        end
      end
      S_PRED: begin
        p_nxt     = p_pred;
        state_nxt = S_DIV;
      end
      S_DIV: begin
        alu_op = 1'b1;
        alu_a  = p_q;
        alu_b  = div_b;
        // A zero denominator only happens with P=R=0; skip the ALU and use K=0.
        if (div_b == '0) begin
          k_nxt     = '0;
          state_nxt = S_MUL_X;
        end else begin
          alu_req = 1'b1;
          if (alu_ack) begin
            k_nxt     = k_sat;
            state_nxt = S_MUL_X;
          end
        end
      end
      S_MUL_X: begin
        alu_req = 1'b1;
        alu_a   = innov;
        alu_b   = k_ext;
        if (alu_ack) begin
          dx_nxt    = alu_y;
          state_nxt = S_UPD_X;
        end
      end
      S_UPD_X: begin
        x_nxt     = x_sum;
        state_nxt = S_MUL_P;
      end
      S_MUL_P: begin
        alu_req = 1'b1;
        alu_a   = p_q;
        alu_b   = ONE - k_ext;
        if (alu_ack) begin
          p_nxt     = alu_y[W-1] ? '0 : alu_y;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign meas_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign est_valid  = (state == S_DONE);
  assign est_x      = x_q;
  assign est_p      = p_q;

endmodule

// File: tb/tb_kalman_sched.sv
// Directed bench for kalman_sched with a behavioural shared ALU whose
// response latency is adjustable.
module tb_kalman_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_q, cfg_r, init_x, init_p, meas_z;
  logic        init, meas_valid, meas_ready, est_valid, busy;
  logic [15:0] est_x, est_p;
  logic        alu_req, alu_op, alu_ack;
  logic [15:0] alu_a, alu_b, alu_y;

  int checks = 0;
  int failures = 0;

  int   alu_delay = 0;
  bit   spur_ack = 1'b0;
  int   wait_cnt = 0;
  int   unstable_cnt = 0;
  logic h_op;
  logic [15:0] h_a, h_b;
  logic        log_op[$];
  logic [15:0] log_a[$];
  logic [15:0] log_b[$];

  always #5 clk = ~clk;

  kalman_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_q(cfg_q), .cfg_r(cfg_r),
    .init(init), .init_x(init_x), .init_p(init_p),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_z(meas_z),
    .est_valid(est_valid), .est_x(est_x), .est_p(est_p), .busy(busy),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ack(alu_ack), .alu_y(alu_y)
  );

  function automatic logic [15:0] alu_calc(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] prod;
    logic [23:0] quo;
    if (op) begin
      if (b == 16'h0) return 16'hFFFF;
      quo = {a, 8'h00} / {8'h00, b};
      return (quo > 24'h00FFFF) ? 16'hFFFF : quo[15:0];
    end
    prod = ($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b})) >>> 8;
    if (prod > 32767) return 16'h7FFF;
    if (prod < -32768) return 16'h8000;
    return prod[15:0];
  endfunction

  // External ALU: acks after alu_delay wait cycles, logs each completed request.
  always @(negedge clk) begin
    if (alu_ack) wait_cnt = 0;
    if (!rst_n) begin
      alu_ack  = 1'b0;
      wait_cnt = 0;
    end else if (alu_req) begin
      if (wait_cnt == 0) begin
        h_op = alu_op; h_a = alu_a; h_b = alu_b;
      end else if ({alu_op, alu_a, alu_b} !== {h_op, h_a, h_b}) begin
        unstable_cnt++;
      end
      if (wait_cnt == alu_delay) begin
        alu_ack = 1'b1;
        alu_y   = alu_calc(alu_op, alu_a, alu_b);
        log_op.push_back(alu_op); log_a.push_back(alu_a); log_b.push_back(alu_b);
      end else begin
        alu_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      alu_ack  = spur_ack;
      alu_y    = 16'h5A5A;
      wait_cnt = 0;
    end
  end

  function automatic logic [32:0] log_entry(input int i);
    if (i < log_a.size()) return {log_op[i], log_a[i], log_b[i]};
    return '1;
  endfunction

  task automatic clear_log();
    log_op.delete(); log_a.delete(); log_b.delete();
    unstable_cnt = 0;
  endtask

  task automatic init_state(input logic [15:0] x, input logic [15:0] p);
    init = 1'b1; init_x = x; init_p = p;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  // Starts a step from IDLE; lat = cycle index after the accept edge that shows est_valid.
  // Returns one cycle after DONE. Optionally holds junk on init during the early step.
  task automatic run_step(input logic [15:0] z, input bit pulse_init, output int lat);
    meas_z = z; meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_valid = 1'b0;
    if (pulse_init) begin
      init = 1'b1; init_x = 16'h1234; init_p = 16'h0500;
    end
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (est_valid) begin
        lat = i;
        break;
      end
      if (i == 4) init = 1'b0;
      @(posedge clk); #1;
    end
    init = 1'b0;
    if (lat != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({meas_ready, busy, est_valid, alu_req} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1000", {meas_ready, busy, est_valid, alu_req});
    end
    checks++;
    if ({est_x, est_p} !== {16'h0000, 16'h0100}) begin
      failures++;
      $display("FAIL reset_xp got=%h/%h exp=0000/0100", est_x, est_p);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int lat;
    cfg_q = 16'h0100; cfg_r = 16'h0100;
    init_state(16'h0000, 16'h0100);
    clear_log();
    alu_delay = 0;
    run_step(16'h0A00, 1'b0, lat);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL nominal_latency got=%0d exp=6", lat); end
    checks++;
    if (est_x !== 16'h06A4) begin failures++; $display("FAIL nominal_x got=%h exp=06a4", est_x); end
    checks++;
    if (est_p !== 16'h00AC) begin failures++; $display("FAIL nominal_p got=%h exp=00ac", est_p); end
    checks++;
    if ({est_valid, meas_ready} !== 2'b01) begin
      failures++; $display("FAIL nominal_pulse_end got=%b exp=01", {est_valid, meas_ready});
    end
    checks++;
    if (log_a.size() !== 3) begin failures++; $display("FAIL nominal_reqs got=%0d exp=3", log_a.size()); end
    checks++;
    if (log_entry(0) !== {1'b1, 16'h0200, 16'h0300}) begin
      failures++; $display("FAIL nominal_div got=%h exp=%h", log_entry(0), {1'b1, 16'h0200, 16'h0300});
    end
    checks++;
    if (log_entry(1) !== {1'b0, 16'h0A00, 16'h00AA}) begin
      failures++; $display("FAIL nominal_mulx got=%h exp=%h", log_entry(1), {1'b0, 16'h0A00, 16'h00AA});
    end
    checks++;
    if (log_entry(2) !== {1'b0, 16'h0200, 16'h0056}) begin
      failures++; $display("FAIL nominal_mulp got=%h exp=%h", log_entry(2), {1'b0, 16'h0200, 16'h0056});
    end
  endtask

  task automatic test_wait_states();
    int lat;
    cfg_q = 16'h0100; cfg_r = 16'h0100;
    init_state(16'h0000, 16'h0100);
    clear_log();
    alu_delay = 3;
    run_step(16'h0A00, 1'b0, lat);
    alu_delay = 0;
    checks++;
    if (lat !== 15) begin failures++; $display("FAIL wait_latency got=%0d exp=15", lat); end
    checks++;
    if ({est_x, est_p} !== {16'h06A4, 16'h00AC}) begin
      failures++; $display("FAIL wait_xp got=%h/%h exp=06a4/00ac", est_x, est_p);
    end
    checks++;
    if (unstable_cnt !== 0) begin failures++; $display("FAIL wait_stable got=%0d exp=0", unstable_cnt); end
    checks++;
    if (log_entry(1) !== {1'b0, 16'h0A00, 16'h00AA}) begin
      failures++; $display("FAIL wait_mulx got=%h exp=%h", log_entry(1), {1'b0, 16'h0A00, 16'h00AA});
    end
  endtask

  task automatic test_degenerate();
    int lat, n_div;
    cfg_q = 16'h0000; cfg_r = 16'h0000;
    init_state(16'h0300, 16'h0000);
    clear_log();
    run_step(16'h0500, 1'b0, lat);
    n_div = 0;
    foreach (log_op[i]) if (log_op[i]) n_div++;
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL degen_latency got=%0d exp=6", lat); end
    checks++;
    if ({est_x, est_p} !== {16'h0300, 16'h0000}) begin
      failures++; $display("FAIL degen_xp got=%h/%h exp=0300/0000", est_x, est_p);
    end
    checks++;
    if (n_div !== 0 || log_a.size() !== 2) begin
      failures++; $display("FAIL degen_reqs got div=%0d total=%0d exp div=0 total=2", n_div, log_a.size());
    end
    checks++;
    if (log_entry(0) !== {1'b0, 16'h0200, 16'h0000} || log_entry(1) !== {1'b0, 16'h0000, 16'h0100}) begin
      failures++; $display("FAIL degen_ops got=%h/%h exp=%h/%h", log_entry(0), log_entry(1),
                           {1'b0, 16'h0200, 16'h0000}, {1'b0, 16'h0000, 16'h0100});
    end
  endtask

  task automatic test_saturation();
    int lat;
    cfg_q = 16'hFFFF; cfg_r = 16'h0100;
    init_state(16'h7F00, 16'hFFFF);
    checks++;
    if (est_p !== 16'h7FFF) begin failures++; $display("FAIL sat_init_p got=%h exp=7fff", est_p); end
    clear_log();
    run_step(16'h8000, 1'b0, lat);
    checks++;
    if (log_entry(0) !== {1'b1, 16'h7FFF, 16'h7FFF}) begin
      failures++; $display("FAIL sat_div got=%h exp=%h", log_entry(0), {1'b1, 16'h7FFF, 16'h7FFF});
    end
    checks++;
    if (log_entry(1) !== {1'b0, 16'h8000, 16'h00FF}) begin
      failures++; $display("FAIL sat_mulx got=%h exp=%h", log_entry(1), {1'b0, 16'h8000, 16'h00FF});
    end
    checks++;
    if ({est_x, est_p} !== {16'hFF80, 16'h007F}) begin
      failures++; $display("FAIL sat_xp got=%h/%h exp=ff80/007f", est_x, est_p);
    end
  endtask

  task automatic test_handshake();
    int lat, n_ready, n_est, n_both;
    cfg_q = 16'h0100; cfg_r = 16'h0100;
    init_state(16'h0000, 16'h0100);
    n_ready = 0; n_est = 0; n_both = 0;
    meas_z = 16'h0A00; meas_valid = 1'b1;
    for (int t = 0; t < 14; t++) begin
      n_ready += int'(meas_ready);
      n_est   += int'(est_valid);
      n_both  += int'(meas_ready & est_valid);
      if (t == 13) meas_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (n_ready !== 2 || n_est !== 2 || n_both !== 0) begin
      failures++; $display("FAIL held_valid got ready=%0d est=%0d both=%0d exp 2/2/0", n_ready, n_est, n_both);
    end
    init = 1'b1; init_x = 16'h0123; init_p = 16'h0200; meas_valid = 1'b1;
    @(posedge clk); #1;
    init = 1'b0; meas_valid = 1'b0;
    checks++;
    if ({busy, est_x, est_p} !== {1'b0, 16'h0123, 16'h0200}) begin
      failures++; $display("FAIL init_wins got=%b/%h/%h exp=0/0123/0200", busy, est_x, est_p);
    end
    init_state(16'h0000, 16'h0100);
    run_step(16'h0A00, 1'b1, lat);
    checks++;
    if ({est_x, est_p} !== {16'h06A4, 16'h00AC}) begin
      failures++; $display("FAIL init_busy got=%h/%h exp=06a4/00ac", est_x, est_p);
    end
    clear_log();
    spur_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    spur_ack = 1'b0;
    checks++;
    if ({busy, est_x, est_p} !== {1'b0, 16'h06A4, 16'h00AC} || log_a.size() !== 0) begin
      failures++; $display("FAIL spurious_ack got=%b/%h/%h reqs=%0d exp=0/06a4/00ac reqs=0",
                           busy, est_x, est_p, log_a.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_step();
    int lat;
    bit found;
    cfg_q = 16'h0100; cfg_r = 16'h0100;
    init_state(16'h0500, 16'h0300);
    alu_delay = 3;
    meas_z = 16'h0A00; meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (alu_req && !alu_op) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_reach_mulx got=0 exp=1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_req, meas_ready, busy, est_x, est_p} !== {3'b010, 16'h0000, 16'h0100}) begin
      failures++; $display("FAIL mid_reset got=%b%b%b/%h/%h exp=010/0000/0100",
                           alu_req, meas_ready, busy, est_x, est_p);
    end
    alu_delay = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    run_step(16'h0A00, 1'b0, lat);
    checks++;
    if (lat !== 6 || est_x !== 16'h06A4 || est_p !== 16'h00AC || log_a.size() !== 3) begin
      failures++; $display("FAIL post_reset_step got lat=%0d x=%h p=%h reqs=%0d exp 6/06a4/00ac/3",
                           lat, est_x, est_p, log_a.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; meas_valid = 1'b0;
    cfg_q = 16'h0; cfg_r = 16'h0; init_x = 16'h0; init_p = 16'h0; meas_z = 16'h0;
    alu_ack = 1'b0; alu_y = 16'h0;
    test_reset();
    test_nominal();
    test_wait_states();
    test_degenerate();
    test_saturation();
    test_handshake();
    test_reset_mid_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
